digest_target_scanner: RTL and testbench
========================================

// Module: digest_target_scanner
// PURPOSE
//   Downstream of the SHA lane bank: takes one snapshot of NUM_LANES finished digests, compares each against the target.
//   Compares one lane per cycle and reports the first winning nonce, or a miss, via a valid/ready result handshake.
//   Replaces the per-lane comparator and output counter that currently sit next to the digest bank.
// PARAMETERS
//   NUM_LANES   10   number of SHA lanes in one snapshot
//   LANE_IDX_W  4    lane index width; NUM_LANES <= 2**LANE_IDX_W - 1
//   DIGEST_W    256  digest and target width
//   NONCE_W     32   nonce width
// PORTS
//   clk            in   1                   clock; all logic on posedge
//   rst            in   1                   synchronous, active-high reset
//   load_valid     in   1                   snapshot offered
//   load_ready     out  1                   scanner can accept a snapshot
//   digests_in     in   NUM_LANES*DIGEST_W  lane i at [i*DIGEST_W +: DIGEST_W]
//   base_nonce     in   NONCE_W             nonce of lane 0; lane i used base_nonce+i
//   target         in   DIGEST_W            hit when digest < target
//   abort          in   1                   drop current work (new message)
//   busy           out  1                   state != IDLE
//   result_valid   out  1                   result held
//   result_ready   in   1                   consumer takes result
//   result_found   out  1                   1 = hit, 0 = all lanes missed
//   result_nonce   out  NONCE_W             winning nonce; 0 on miss
//   result_lane    out  LANE_IDX_W          winning lane; 0 on miss
// BEHAVIOUR
//   Reset:
//     - rst high at posedge -> state IDLE, idx 0, all result_* 0, captured regs 0.
//     - load_ready = (state==IDLE) & ~rst, combinational.
//   FSM states: IDLE, SCAN, REPORT.
//   IDLE:
//     - On load_valid & load_ready: capture digests_in, base_nonce and target; idx<=0; go to SCAN.
//     - Inputs are ignored outside the accept edge.
//   SCAN:
//     - Each cycle compares captured digest[idx] < captured target, unsigned, strict; equal is a miss.
//     - Hit: found<=1, lane<=idx, nonce<=base+idx mod 2^NONCE_W (wraps silently); go to REPORT.
//     - Miss with idx==NUM_LANES-1: found<=0, nonce<=0, lane<=0; go to REPORT. Otherwise idx<=idx+1.
//   REPORT:
//     - result_valid=1; result_* stable until the handshake.
//     - On result_ready: go to IDLE and clear result_valid next cycle.
//     - load_ready is 0 here, so there is no back-to-back overlap.
//   Latency, counted from the accept edge:
//     - First hit at lane k: result_valid rises k+1 cycles later.
//     - Full miss: result_valid rises NUM_LANES cycles later.
//   abort:
//     - Any state -> IDLE at the next edge; result_valid<=0, found/nonce/lane<=0.
//     - abort wins over load_valid and result_ready in the same cycle.
//     - No result is emitted for aborted work.
//   Priority: rst > abort > handshakes.
//   result_ready while result_valid=0 has no effect.
// CONFIGURATION
//   SCAN_ALL_EN undefined:
//     - Early exit on the first hit, as above.
//   SCAN_ALL_EN defined:
//     - Scan never exits early; always NUM_LANES cycles to REPORT.
//     - Reports the hit with the smallest digest; the lowest lane wins ties.
//     - Adds output hit_count [LANE_IDX_W]: number of hitting lanes, 0 on miss, reset 0.
// TESTING
//   1. Lane 3 hit: target=2^255, lanes 0-2 = all-ones, lane 3 = 1, base=0x100
//      -> found=1, lane=3, nonce=0x103, valid 4 cycles after accept.
//   2. Miss: all digests = target
//      -> found=0, nonce=0, valid 10 cycles after accept.
//   3. Wrap: base=0xFFFFFFFE, only lane 3 hits
//      -> nonce=0x00000001, lane=3.
//   4. Backpressure: hold result_ready=0 for 5 cycles in REPORT
//      -> outputs stable, load_ready=0; ready=1 -> IDLE next cycle, load_ready=1.
//   5. Abort during SCAN at idx 2, with load_valid also high
//      -> IDLE next cycle, no result_valid, load not accepted; the next load scans normally.
//   6. SCAN_ALL_EN: lanes 1 and 7 hit, lane 7 smaller
//      -> lane=7, hit_count=2, valid 10 cycles after accept.

Source files
------------

// File: rtl/digest_target_scanner_if.sv
// digest_target_scanner_if: snapshot load, control and result handshake bundle for the digest scanner (hit_count present with SCAN_ALL_EN)
interface digest_target_scanner_if #(
    parameter int NUM_LANES  = 10,
    parameter int LANE_IDX_W = 4,
    parameter int DIGEST_W   = 256,
    parameter int NONCE_W    = 32
);
    logic                          load_valid;
    logic                          load_ready;
    logic [NUM_LANES*DIGEST_W-1:0] digests_in;
    logic [NONCE_W-1:0]            base_nonce;
    logic [DIGEST_W-1:0]           target;
    logic                          abort;
    logic                          busy;
    logic                          result_valid;
    logic                          result_ready;
    logic                          result_found;
    logic [NONCE_W-1:0]            result_nonce;
    logic [LANE_IDX_W-1:0]         result_lane;
`ifdef SCAN_ALL_EN
    logic [LANE_IDX_W-1:0]         hit_count;
`endif

    modport slave (
        input  load_valid, digests_in, base_nonce, target, abort, result_ready,
        output load_ready, busy, result_valid, result_found, result_nonce, result_lane
`ifdef SCAN_ALL_EN
        , output hit_count
`endif
    );

    modport master (
        output load_valid, digests_in, base_nonce, target, abort, result_ready,
        input  load_ready, busy, result_valid, result_found, result_nonce, result_lane
`ifdef SCAN_ALL_EN
        , input hit_count
`endif
    );
endinterface

// File: rtl/digest_target_scanner.sv
// digest_target_scanner: scans one digest snapshot a lane per cycle against the target; SCAN_ALL_EN selects full scan with smallest-digest pick and hit_count
module digest_target_scanner #(
    parameter int NUM_LANES  = 10,
    parameter int LANE_IDX_W = 4,
    parameter int DIGEST_W   = 256,
    parameter int NONCE_W    = 32
) (
    input logic clk,
    input logic rst,
    digest_target_scanner_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]            state;
    logic [LANE_IDX_W-1:0] idx;
    logic [DIGEST_W-1:0]   laneDigest [NUM_LANES];
    logic [NONCE_W-1:0]    capBase;
    logic [DIGEST_W-1:0]   capTarget;
    logic                  resValid;
    logic                  resFound;
    logic [NONCE_W-1:0]    resNonce;
    logic [LANE_IDX_W-1:0] resLane;
    logic [DIGEST_W-1:0]   curDigest;
    logic                  isHit;
    logic                  lastLane;

    assign curDigest = laneDigest[idx];
    assign isHit     = curDigest < capTarget;
    assign lastLane  = idx == LANE_IDX_W'(NUM_LANES - 1);

    assign bus.load_ready   = (state == IDLE) & ~rst;
    assign bus.busy         = state != IDLE;
    assign bus.result_valid = resValid;
    assign bus.result_found = resFound;
    assign bus.result_nonce = resNonce;
    assign bus.result_lane  = resLane;

`ifdef SCAN_ALL_EN
    logic                  haveBest;
    logic [LANE_IDX_W-1:0] bestIdx;
    logic [DIGEST_W-1:0]   bestDigest;
    logic [LANE_IDX_W-1:0] runCount;
    logic [LANE_IDX_W-1:0] hitCount;
    logic                  takeCur;
    logic                  nxtHave;
    logic [LANE_IDX_W-1:0] nxtIdx;
    logic [LANE_IDX_W-1:0] nxtCount;

    // Strict less-than keeps the earlier lane on equal digests
    always_comb begin
        takeCur  = isHit & (~haveBest | (curDigest < bestDigest));
        nxtHave  = haveBest | isHit;
        nxtIdx   = takeCur ? idx : bestIdx;
        nxtCount = runCount + LANE_IDX_W'(isHit);
    end

    assign bus.hit_count = hitCount;
`endif

    // Scanner FSM: capture on accept, compare one lane per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            capBase   <= '0;
            capTarget <= '0;
            for (int i = 0; i < NUM_LANES; i++) laneDigest[i] <= '0;
            resValid  <= 1'b0;
            resFound  <= 1'b0;
            resNonce  <= '0;
            resLane   <= '0;
`ifdef SCAN_ALL_EN
            haveBest   <= 1'b0;
            bestIdx    <= '0;
            bestDigest <= '0;
            runCount   <= '0;
            hitCount   <= '0;
`endif
        end else if (bus.abort) begin
            state    <= IDLE;
            resValid <= 1'b0;
            resFound <= 1'b0;
            resNonce <= '0;
            resLane  <= '0;
`ifdef SCAN_ALL_EN
            hitCount <= '0;
`endif
        end else if (state == IDLE) begin
            if (bus.load_valid) begin
                for (int i = 0; i < NUM_LANES; i++) laneDigest[i] <= bus.digests_in[i*DIGEST_W +: DIGEST_W];
                capBase   <= bus.base_nonce;
                capTarget <= bus.target;
                idx       <= '0;
                state     <= SCAN;
`ifdef SCAN_ALL_EN
                haveBest  <= 1'b0;
                bestIdx   <= '0;
                runCount  <= '0;
`endif
            end
        end else if (state == SCAN) begin
`ifdef SCAN_ALL_EN
            if (lastLane) begin
                resFound <= nxtHave;
                resLane  <= nxtHave ? nxtIdx : '0;
                resNonce <= nxtHave ? capBase + NONCE_W'(nxtIdx) : '0;
                hitCount <= nxtCount;
                resValid <= 1'b1;
                state    <= REPORT;
            end else begin
                idx        <= idx + LANE_IDX_W'(1);
                haveBest   <= nxtHave;
                bestIdx    <= nxtIdx;
                bestDigest <= takeCur ? curDigest : bestDigest;
                runCount   <= nxtCount;
            end
`else
            if (isHit) begin
                resFound <= 1'b1;
                resLane  <= idx;
                resNonce <= capBase + NONCE_W'(idx);
                resValid <= 1'b1;
                state    <= REPORT;
            end else if (lastLane) begin
                resFound <= 1'b0;
                resLane  <= '0;
                resNonce <= '0;
                resValid <= 1'b1;
                state    <= REPORT;
            end else begin
                idx <= idx + LANE_IDX_W'(1);
            end
`endif
        end else if (bus.result_ready) begin
            resValid <= 1'b0;
            state    <= IDLE;
        end
    end
endmodule

// File: tb/tb_digest_target_scanner.sv
// tb_digest_target_scanner: directed and random snapshots checked against a lane-by-lane reference of the target rule
module tb_digest_target_scanner;
    localparam int NL = 10;
    localparam int LW = 4;
    localparam int DW = 256;
    localparam int NW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    logic [DW-1:0] dig [NL];
    logic [DW-1:0] tgt;
    logic [NW-1:0] base;

    digest_target_scanner_if #(.NUM_LANES(NL), .LANE_IDX_W(LW), .DIGEST_W(DW), .NONCE_W(NW)) bus ();

    digest_target_scanner #(.NUM_LANES(NL), .LANE_IDX_W(LW), .DIGEST_W(DW), .NONCE_W(NW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic driveSnapshot();
        for (int i = 0; i < NL; i++) bus.digests_in[i*DW +: DW] = dig[i];
        bus.base_nonce = base;
        bus.target = tgt;
    endtask

    task automatic scramble();
        for (int i = 0; i < NL; i++) bus.digests_in[i*DW +: DW] = rand256();
        bus.base_nonce = $urandom;
        bus.target = rand256();
    endtask

    // Reference: a lane hits when its digest is strictly below the target
    task automatic model(output logic f, output logic [LW-1:0] l, output logic [NW-1:0] n,
                         output int lat, output int cnt);
        logic [DW-1:0] best;
        f = 1'b0; l = '0; n = '0; cnt = 0; best = '0;
        for (int i = 0; i < NL; i++) begin
            if (dig[i] < tgt) begin
                cnt++;
`ifdef SCAN_ALL_EN
                if (!f || dig[i] < best) begin
`else
                if (!f) begin
`endif
                    f = 1'b1; l = LW'(i); best = dig[i];
                end
            end
        end
        n = f ? base + NW'(l) : '0;
`ifdef SCAN_ALL_EN
        lat = NL;
`else
        lat = f ? int'(l) + 1 : NL;
`endif
    endtask

    task automatic runTxn(input string name, input int hold, input bit earlyReady);
        logic f; logic [LW-1:0] l; logic [NW-1:0] n; int lat; int cnt; int got;
        model(f, l, n, lat, cnt);
        driveSnapshot();
        bus.load_valid = 1'b1;
        chk({name, ".load_ready"}, 64'(bus.load_ready), 64'd1);
        tick();
        bus.load_valid = 1'b0;
        scramble();
        bus.result_ready = earlyReady;
        got = 0;
        do begin
            tick();
            got++;
        end while (!bus.result_valid && got < 40);
        chk({name, ".latency"}, 64'(got), 64'(lat));
        chk({name, ".found"}, 64'(bus.result_found), 64'(f));
        chk({name, ".lane"}, 64'(bus.result_lane), 64'(l));
        chk({name, ".nonce"}, 64'(bus.result_nonce), 64'(n));
`ifdef SCAN_ALL_EN
        chk({name, ".hit_count"}, 64'(bus.hit_count), 64'(cnt));
`endif
        if (!earlyReady) begin
            for (int c = 0; c < hold; c++) begin
                tick();
                chk({name, ".hold_valid"}, 64'(bus.result_valid), 64'd1);
                chk({name, ".hold_nonce"}, 64'(bus.result_nonce), 64'(n));
                chk({name, ".hold_lane"}, 64'(bus.result_lane), 64'(l));
                chk({name, ".hold_load_ready"}, 64'(bus.load_ready), 64'd0);
            end
            bus.result_ready = 1'b1;
        end
        tick();
        bus.result_ready = 1'b0;
        chk({name, ".post_valid"}, 64'(bus.result_valid), 64'd0);
        chk({name, ".post_load_ready"}, 64'(bus.load_ready), 64'd1);
        chk({name, ".post_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.abort = 1'b0;
        bus.result_ready = 1'b0;
        scramble();
        tick();
        tick();
        chk("reset.load_ready", 64'(bus.load_ready), 64'd0);
        chk("reset.valid", 64'(bus.result_valid), 64'd0);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.nonce", 64'(bus.result_nonce), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset.release_load_ready", 64'(bus.load_ready), 64'd1);

        tgt = DW'(1) << 255;
        for (int i = 0; i < NL; i++) dig[i] = '1;
        dig[3] = DW'(1);
        base = 32'h100;
        runTxn("lane3_backpressure", 5, 1'b0);

        tgt = rand256();
        for (int i = 0; i < NL; i++) dig[i] = tgt;
        base = $urandom;
        runTxn("equal_miss", 0, 1'b1);

        tgt = DW'(1) << 255;
        for (int i = 0; i < NL; i++) dig[i] = '1;
        dig[3] = '0;
        base = 32'hFFFF_FFFE;
        runTxn("wrap", 1, 1'b0);

        tgt = DW'(1) << 255;
        for (int i = 0; i < NL; i++) dig[i] = '1;
        dig[NL-1] = tgt - DW'(1);
        base = 32'h8000_0000;
        runTxn("last_lane", 0, 1'b0);

`ifdef SCAN_ALL_EN
        tgt = DW'(1) << 255;
        for (int i = 0; i < NL; i++) dig[i] = '1;
        dig[1] = DW'(100);
        dig[7] = DW'(5);
        base = 32'h10;
        runTxn("scan_all_min", 0, 1'b0);
        dig[1] = DW'(5);
        runTxn("scan_all_tie", 0, 1'b0);
`endif

        tgt = DW'(1) << 255;
        for (int i = 0; i < NL; i++) dig[i] = '1;
        base = 32'h55;
        driveSnapshot();
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tick();
        tick();
        bus.abort = 1'b1;
        bus.load_valid = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.load_valid = 1'b0;
        bus.result_ready = 1'b0;
        chk("abort_scan.busy", 64'(bus.busy), 64'd0);
        chk("abort_scan.valid", 64'(bus.result_valid), 64'd0);
        chk("abort_scan.load_ready", 64'(bus.load_ready), 64'd1);
        for (int c = 0; c < NL + 2; c++) begin
            tick();
            chk("abort_scan.no_result", 64'(bus.result_valid), 64'd0);
        end

        dig[2] = '0;
        base = 32'h200;
        driveSnapshot();
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int c = 0; c < NL + 2 && !bus.result_valid; c++) tick();
        chk("abort_report.valid_before", 64'(bus.result_valid), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_report.valid", 64'(bus.result_valid), 64'd0);
        chk("abort_report.found", 64'(bus.result_found), 64'd0);
        chk("abort_report.nonce", 64'(bus.result_nonce), 64'd0);
        chk("abort_report.lane", 64'(bus.result_lane), 64'd0);

        for (int t = 0; t < 30; t++) begin
            tgt = rand256() >> $urandom_range(0, 6);
            for (int i = 0; i < NL; i++) dig[i] = ($urandom_range(0, 7) == 0) ? tgt : rand256();
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + NW'($urandom_range(0, 7)) : $urandom;
            runTxn("random", $urandom_range(0, 3), 1'(($urandom_range(0, 3) == 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
